// File: rtl/fp_sqrt_pkg.sv
// Shared types and width/bias helpers for the iterative floating-point square root.
package fp_sqrt_pkg;

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_ROUND, S_FIN} state_e;

  typedef struct packed {
    logic nan;
    logic pinf;
    logic ninf;
    logic zero;
  } flags_t;

  function automatic int bias_f(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int width_f(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int cnt_w_f(input int man_w);
    return $clog2(man_w + 3);
  endfunction

  // Sign, all-ones exponent and mantissa MSB set; caller truncates to its width.
  function automatic logic [63:0] qnan_f(input int exp_w, input int man_w);
    return ((64'd1 << (exp_w + 2)) - 64'd1) << (man_w - 1);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand class decode: sign, zero, subnormal, normal, infinity, NaN.
module fp_classify
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] in_i,
  output logic                 sign_o,
  output logic                 zero_o,
  output logic                 sub_o,
  output logic                 norm_o,
  output logic                 inf_o,
  output logic                 nan_o
);
  localparam int W = width_f(EXP_W, MAN_W);

  logic ex_zero, ex_ones, man_zero;

  assign ex_zero  = (in_i[W-2:MAN_W] == '0);
  assign ex_ones  = (in_i[W-2:MAN_W] == '1);
  assign man_zero = (in_i[MAN_W-1:0] == '0);

  assign sign_o = in_i[W-1];
  assign zero_o = ex_zero & man_zero;
  assign sub_o  = ex_zero & ~man_zero;
  assign inf_o  = ex_ones & man_zero;
  assign nan_o  = ex_ones & ~man_zero;
  assign norm_o = ~ex_zero & ~ex_ones;

endmodule

// File: rtl/fp_sqrt_n.sv
// Multi-cycle square root: subnormal pre-normalisation, restoring recurrence
// (one root bit per cycle), then round-to-nearest-even.
module fp_sqrt_n
  import fp_sqrt_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [EXP_W+MAN_W:0] IN_DATA,
  output logic               BUSY,
  output logic               DONE,
  output logic [EXP_W+MAN_W:0] OUT_DATA,
  output logic               IS_NAN,
  output logic               IS_PINF,
  output logic               IS_NINF,
  output logic               IS_ZERO
);
  localparam int W  = width_f(EXP_W, MAN_W);
  localparam int N  = MAN_W + 2;
  localparam int RW = MAN_W + 4;
  localparam int CW = cnt_w_f(MAN_W);
  localparam int EW = EXP_W + 7;
  localparam int B  = bias_f(EXP_W);
  localparam logic [W-1:0] QNAN = W'(qnan_f(EXP_W, MAN_W));
  localparam logic [W-1:0] QBIT = W'(1) << (MAN_W - 1);

  function automatic logic [MAN_W+1:0] radicand_f(input logic [MAN_W:0] m, input logic odd);
    return odd ? {m, 1'b0} : {1'b0, m};
  endfunction

  function automatic logic [W-1:0] round_f(input logic [N-2:0] q, input logic sticky,
                                           input logic [EXP_W-1:0] ex);
    logic       up;
    logic [MAN_W:0] m;
    up = q[0] & (sticky | q[1]);
    m  = {1'b0, q[N-2:1]} + {{MAN_W{1'b0}}, up};
    return {1'b0, ex + {{(EXP_W-1){1'b0}}, m[MAN_W]}, m[MAN_W-1:0]};
  endfunction

  state_e                state_q, state_d;
  logic [MAN_W+1:0]      r_q, r_d;
  logic signed [EW-1:0]  e_q, e_d, e_ld;
  logic [RW-1:0]         rem_q, rem_d, rem_sh, trial;
  logic [N-1:0]          root_q, root_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [W-1:0]          out_q, out_d, sp_out;
  flags_t                flg_q, flg_d, sp_flg;
  logic                  cls_sign, cls_zero, cls_sub, cls_norm, cls_inf, cls_nan;
  logic                  special, ge;
  logic [MAN_W:0]        mant_sh;
  logic [EXP_W-1:0]      ex_res;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls (
    .in_i  (IN_DATA),
    .sign_o(cls_sign),
    .zero_o(cls_zero),
    .sub_o (cls_sub),
    .norm_o(cls_norm),
    .inf_o (cls_inf),
    .nan_o (cls_nan)
  );

  assign special = cls_nan | cls_zero | cls_sign | cls_inf;
  assign e_ld    = $signed({{(EW-EXP_W){1'b0}}, IN_DATA[W-2:MAN_W]}) - EW'(B);
  assign mant_sh = {r_q[MAN_W-1:0], 1'b0};
  // Arithmetic shift gives floor(e/2) for negative exponents as well.
  assign ex_res  = EXP_W'((e_q >>> 1) + EW'(B));
  assign rem_sh  = {rem_q[RW-3:0], r_q[MAN_W+1:MAN_W]};
  assign trial   = {root_q, 2'b01};
  assign ge      = (rem_sh >= trial);

  always_comb begin
    sp_out = IN_DATA;
    sp_flg = '0;
    if (cls_nan) begin
      sp_out     = IN_DATA | QBIT;
      sp_flg.nan = 1'b1;
    end else if (cls_zero) begin
      sp_flg.zero = 1'b1;
    end else if (cls_sign) begin
      sp_out      = QNAN;
      sp_flg.nan  = 1'b1;
      sp_flg.ninf = cls_inf;
    end else if (cls_inf) begin
      sp_flg.pinf = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START) state_d = special ? S_FIN : (cls_norm ? S_ITER : S_NORM);
      S_NORM:  if (mant_sh[MAN_W]) state_d = S_ITER;
      S_ITER:  if (cnt_q == CW'(MAN_W + 1)) state_d = S_ROUND;
      S_ROUND: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_q != S_IDLE);
    DONE = (state_q == S_FIN);
  end

  always_comb begin
    r_d    = r_q;
    e_d    = e_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    flg_d  = flg_q;
    case (state_q)
      S_IDLE: if (START) begin
        rem_d  = '0;
        root_d = '0;
        cnt_d  = '0;
        if (special) begin
          out_d = sp_out;
          flg_d = sp_flg;
        end else if (cls_sub) begin
          r_d = {2'b00, IN_DATA[MAN_W-1:0]};
          e_d = EW'(1 - B);
        end else begin
          r_d = radicand_f({1'b1, IN_DATA[MAN_W-1:0]}, e_ld[0]);
          e_d = e_ld;
        end
      end
      S_NORM: begin
        e_d = e_q - EW'(1);
        r_d = mant_sh[MAN_W] ? radicand_f(mant_sh, e_d[0]) : {1'b0, mant_sh};
      end
      S_ITER: begin
        r_d    = r_q << 2;
        rem_d  = ge ? rem_sh - trial : rem_sh;
        root_d = {root_q[N-2:0], ge};
        cnt_d  = cnt_q + CW'(1);
      end
      S_ROUND: begin
        out_d = round_f(root_q[N-2:0], |rem_q, ex_res);
        flg_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q    <= '0;
      e_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      flg_q  <= '0;
    end else begin
      r_q    <= r_d;
      e_q    <= e_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      flg_q  <= flg_d;
    end
  end

  assign OUT_DATA = out_q;
  assign IS_NAN   = flg_q.nan;
  assign IS_PINF  = flg_q.pinf;
  assign IS_NINF  = flg_q.ninf;
  assign IS_ZERO  = flg_q.zero;

endmodule

// File: tb/tb_fp_sqrt_n.sv
// Scoreboard bench for fp_sqrt_n: binary16 and binary32 instances, directed vectors.
module tb_fp_sqrt_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_a, st_b;
  logic [15:0] din_a, out_a;
  logic [31:0] din_b, out_b;
  logic        busy_a, done_a, nan_a, pinf_a, ninf_a, zero_a;
  logic        busy_b, done_b, nan_b, pinf_b, ninf_b, zero_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  flg;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // flags order {nan, pinf, ninf, zero}
  logic [15:0] v_in  [12] = '{16'h4400, 16'h4000, 16'h7BFF, 16'h3800, 16'h3400, 16'h0001,
                              16'h0200, 16'hC400, 16'hFC00, 16'h7C01, 16'h7C00, 16'h8000};
  logic [15:0] v_out [12] = '{16'h4000, 16'h3DA8, 16'h5BFF, 16'h39A8, 16'h3800, 16'h0C00,
                              16'h1DA8, 16'hFE00, 16'hFE00, 16'h7E01, 16'h7C00, 16'h8000};
  logic [3:0]  v_flg [12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                              4'h0, 4'h8, 4'hA, 4'h8, 4'h4, 4'h1};
  int          v_lat [12] = '{13, 13, 13, 13, 13, 23, 14, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_sqrt_n #(.EXP_W(5), .MAN_W(10)) dut_a (
    .CLK(clk), .RESET(rst), .START(st_a), .IN_DATA(din_a),
    .BUSY(busy_a), .DONE(done_a), .OUT_DATA(out_a),
    .IS_NAN(nan_a), .IS_PINF(pinf_a), .IS_NINF(ninf_a), .IS_ZERO(zero_a)
  );

  fp_sqrt_n #(.EXP_W(8), .MAN_W(23)) dut_b (
    .CLK(clk), .RESET(rst), .START(st_b), .IN_DATA(din_b),
    .BUSY(busy_b), .DONE(done_b), .OUT_DATA(out_b),
    .IS_NAN(nan_b), .IS_PINF(pinf_b), .IS_NINF(ninf_b), .IS_ZERO(zero_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit wide, input logic [31:0] din, input logic [31:0] res,
                       input logic [3:0] flg, input int lat);
    exp_t e;
    int   n = 0;
    while ((wide ? busy_b : busy_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got BUSY=1 for %0d cycles, expected idle", n);
      return;
    end
    e.data = res;
    e.flg  = flg;
    e.due  = cyc + 1 + lat;
    if (wide) begin
      st_b  = 1'b1;
      din_b = din;
      qb.push_back(e);
    end else begin
      st_a  = 1'b1;
      din_a = din[15:0];
      qa.push_back(e);
    end
    @(negedge clk);
    st_a = 1'b0;
    st_b = 1'b0;
  endtask

  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_spurious_done: got DONE with %h, expected no DONE", out_a);
      end else begin
        ea = qa.pop_front();
        chk("a_data", {16'h0, out_a}, ea.data);
        chk("a_flags", {28'h0, nan_a, pinf_a, ninf_a, zero_a}, {28'h0, ea.flg});
        chk("a_latency", 32'(cyc), 32'(ea.due));
      end
    end
  end

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_spurious_done: got DONE with %h, expected no DONE", out_b);
      end else begin
        eb = qb.pop_front();
        chk("b_data", out_b, eb.data);
        chk("b_flags", {28'h0, nan_b, pinf_b, ninf_b, zero_b}, {28'h0, eb.flg});
        chk("b_latency", 32'(cyc), 32'(eb.due));
      end
    end
  end

  initial begin
    int n;
    rst   = 1'b1;
    st_a  = 1'b0;
    st_b  = 1'b0;
    din_a = '0;
    din_b = '0;
    repeat (2) @(negedge clk);
    chk("a_reset_state", {10'h0, busy_a, done_a, nan_a, pinf_a, ninf_a, zero_a, out_a}, 32'h0);
    chk("b_reset_out", out_b, 32'h0);
    chk("b_reset_ctl", {26'h0, busy_b, done_b, nan_b, pinf_b, ninf_b, zero_b}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      issue(1'b0, {16'h0, v_in[i]}, {16'h0, v_out[i]}, v_flg[i], v_lat[i]);

    // Abort an operation with reset; the aborted request must never complete.
    issue(1'b0, 32'h4400, 32'h4000, 4'h0, 13);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    qa.delete();
    chk("a_abort_state", {10'h0, busy_a, done_a, nan_a, pinf_a, ninf_a, zero_a, out_a}, 32'h0);
    rst = 1'b0;
    issue(1'b0, 32'h3C00, 32'h3C00, 4'h0, 13);

    // binary32 instance, with START pulses during BUSY that must be ignored.
    issue(1'b1, 32'h40000000, 32'h3FB504F3, 4'h0, 26);
    repeat (3) begin
      st_b  = 1'b1;
      din_b = 32'h40800000;
      @(negedge clk);
      st_b  = 1'b0;
      @(negedge clk);
    end
    issue(1'b1, 32'hFF800000, 32'hFFC00000, 4'hA, 0);
    issue(1'b1, 32'h40800000, 32'h40000000, 4'h0, 26);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(qa.size() + qb.size()), 32'h0);

    repeat (3) @(negedge clk);
    chk("a_hold", {16'h0, out_a}, 32'h3C00);
    chk("b_hold", out_b, 32'h40000000);
    chk("idle_after", {30'h0, busy_a, busy_b}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
